// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator controller: floor indices,
// scheduler states and the travel direction used by the request scheduler.
package elevator_pkg;

  localparam int N_FLOORS = 8;
  localparam int FLOOR_W  = 3;

  typedef logic [FLOOR_W-1:0] floor_t;

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DOWN
  } sched_state_t;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_t;

  // One-hot mask with only the bit of floor f set.
  function automatic logic [N_FLOORS-1:0] floor_mask(input floor_t f);
    logic [N_FLOORS-1:0] m;
    m    = '0;
    m[f] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/floor_select.sv
// Combinational priority finder for the scheduler. Reports the lowest
// pending floor at or above the car, the highest pending floor at or below
// it, whether anything lies ahead in the current direction, and the nearest
// pending floor (ties resolved towards the floor above).
module floor_select
  import elevator_pkg::*;
(
  input  logic [N_FLOORS-1:0] pending,
  input  floor_t              cur_floor,
  input  dir_t                dir,
  output logic                found_up,
  output floor_t              target_up,
  output logic                found_down,
  output floor_t              target_down,
  output logic                found_ahead,
  output floor_t              target_near
);

  floor_t dist_up;
  floor_t dist_down;

  // Scan downwards so the last hit kept is the lowest pending floor >= car.
  always_comb begin
    found_up  = 1'b0;
    target_up = '0;
    for (int i = N_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (i >= int'(cur_floor))) begin
        found_up  = 1'b1;
        target_up = floor_t'(i);
      end
    end
  end

  // Scan upwards so the last hit kept is the highest pending floor <= car.
  always_comb begin
    found_down  = 1'b0;
    target_down = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (pending[i] && (i <= int'(cur_floor))) begin
        found_down  = 1'b1;
        target_down = floor_t'(i);
      end
    end
  end

  assign found_ahead = (dir == DIR_UP) ? found_up : found_down;

  // Nearest pending floor; an equal distance goes to the floor above.
  always_comb begin
    dist_up     = target_up - cur_floor;
    dist_down   = cur_floor - target_down;
    target_near = cur_floor;
    if (found_up && found_down) begin
      target_near = (dist_up <= dist_down) ? target_up : target_down;
    end else if (found_up) begin
      target_near = target_up;
    end else if (found_down) begin
      target_near = target_down;
    end
  end

endmodule

// File: rtl/request_scheduler.sv
// Request scheduler for the elevator controller. Latches call buttons into a
// pending register, retires requests when the door opens at their floor and
// picks the next floor with a direction-preserving SCAN policy.
module request_scheduler
  import elevator_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] btn,
  input  logic [FLOOR_W-1:0]  etaj_curent,
  input  logic                door_status,
  output logic [FLOOR_W-1:0]  etaj_cerut,
  output logic [N_FLOORS-1:0] pending,
  output logic                idle
);

  floor_t              etaj_s1;
  floor_t              etaj_s2;
  floor_t              etaj_s3;
  floor_t              cur_floor;
  logic                door_s1;
  logic                door_s2;
  logic                door_open;
  logic [N_FLOORS-1:0] btn_prev;
  logic [N_FLOORS-1:0] btn_rise;
  logic [N_FLOORS-1:0] clear_mask;
  logic                drop_q;
  logic                update_ok;
  sched_state_t        state;
  dir_t                dir;

  logic   found_up;
  floor_t target_up;
  logic   found_down;
  floor_t target_down;
  logic   found_ahead;
  floor_t target_near;

  // Bring the slow-domain floor and door signals across; floor only updates on two equal samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      etaj_s1   <= '0;
      etaj_s2   <= '0;
      etaj_s3   <= '0;
      cur_floor <= '0;
      door_s1   <= 1'b0;
      door_s2   <= 1'b0;
    end else begin
      etaj_s1 <= etaj_curent;
      etaj_s2 <= etaj_s1;
      etaj_s3 <= etaj_s2;
      if (etaj_s2 == etaj_s3) begin
        cur_floor <= etaj_s2;
      end
      door_s1 <= door_status;
      door_s2 <= door_s1;
    end
  end

  assign door_open  = door_s2;
  assign btn_rise   = btn & ~btn_prev;
  assign clear_mask = door_open ? floor_mask(cur_floor) : '0;
  assign idle       = ~|pending;
  assign update_ok  = ~door_open | drop_q;

  // Capture button edges and retire the served floor; a clear beats a simultaneous set.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= '0;
      btn_prev <= '0;
      drop_q   <= 1'b0;
    end else begin
      pending  <= (pending | btn_rise) & ~clear_mask;
      btn_prev <= btn;
      drop_q   <= |(pending & clear_mask);
    end
  end

  floor_select u_floor_select (
    .pending     (pending),
    .cur_floor   (cur_floor),
    .dir         (dir),
    .found_up    (found_up),
    .target_up   (target_up),
    .found_down  (found_down),
    .target_down (target_down),
    .found_ahead (found_ahead),
    .target_near (target_near)
  );

  // SCAN state machine; target is frozen while the door is open unless a request was just retired.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dir        <= DIR_UP;
      etaj_cerut <= '0;
    end else if (update_ok) begin
      case (state)
        IDLE: begin
          if (idle) begin
            etaj_cerut <= cur_floor;
          end else begin
            etaj_cerut <= target_near;
            if (target_near > cur_floor) begin
              state <= UP;
              dir   <= DIR_UP;
            end else if (target_near < cur_floor) begin
              state <= DOWN;
              dir   <= DIR_DOWN;
            end
          end
        end
        UP: begin
          if (idle) begin
            state      <= IDLE;
            etaj_cerut <= cur_floor;
          end else if (found_ahead) begin
            etaj_cerut <= target_up;
          end else begin
            state      <= DOWN;
            dir        <= DIR_DOWN;
            etaj_cerut <= target_down;
          end
        end
        DOWN: begin
          if (idle) begin
            state      <= IDLE;
            etaj_cerut <= cur_floor;
          end else if (found_ahead) begin
            etaj_cerut <= target_down;
          end else begin
            state      <= UP;
            dir        <= DIR_UP;
            etaj_cerut <= target_up;
          end
        end
        default: begin
          state      <= IDLE;
          etaj_cerut <= cur_floor;
        end
      endcase
    end
  end

endmodule
